div_seq_32b: RTL and testbench



---
 rtl/div_seq_32b_pkg.sv | 26 ++
 rtl/div_seq_32b_sub.sv | 30 +++
 rtl/div_seq_32b.sv | 156 +++++++++++++++
 tb/tb_div_seq_32b.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_32b_pkg.sv
// Shared constants and helpers for the sequential 32-bit restoring divider.
package div_seq_32b_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  // Count value seen on the final ITER edge before moving to FIX.
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

  // Controller state encoding (2 bits, kept as plain constants).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Two's complement negation, used for operand magnitude and result sign fix-up.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a value that is signed only when is_sgn is set.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_sgn);
    return (is_sgn && x[WIDTH-1]) ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_seq_32b_sub.sv
// 32-bit ripple subtractor: O = A - B - C_in, C_out is the borrow out of bit 31,
// V flags signed overflow. This is the single arithmetic resource of the divider.
module sub_32b (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        C_in,
  output logic [31:0] O,
  output logic        C_out,
  output logic        V
);

  logic [31:0] diff;
  logic        borrow;

  // Bit-serial borrow chain from LSB to MSB.
  always_comb begin
    // NOTE: blocking assignments here so each bit sees the borrow just produced
    // by the bit below it; a non-blocking chain would read stale values.
    borrow = C_in;
    diff   = '0;
    for (int i = 0; i < 32; i++) begin
      diff[i] = A[i] ^ B[i] ^ borrow;
      borrow  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow);
    end
    O     = diff;
    C_out = borrow;
    V     = (A[31] ^ B[31]) & (diff[31] ^ A[31]);
  end

endmodule

// File: rtl/div_seq_32b.sv
// Multi-cycle restoring divider for the HI/LO divide path (div/divu).
// One shared subtractor is stepped over 32 iterations; signed operation divides
// magnitudes and fixes the signs of quotient and remainder in a final FIX cycle.
module div_seq_32b #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cancel,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  import div_seq_32b_pkg::*;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;       // divisor magnitude
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] shift_val;      // partial remainder shifted left with next dividend bit
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  logic             sub_v_unused;

  // The partial remainder stays below 2^31 before every shift, so dropping r_q[31]
  // here loses nothing.
  assign shift_val = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  sub_32b u_sub (
    .A     (shift_val),
    .B     (d_q),
    .C_in  (1'b0),
    .O     (sub_diff),
    .C_out (sub_borrow),
    .V     (sub_v_unused)
  );

  // Next-state and datapath control for IDLE -> ITER (x32) -> FIX -> IDLE.
  always_comb begin
    // NOTE: every _d starts as its _q (done as 0) so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          state_d   = ST_ITER;
          q_d       = magnitude(dividend, is_signed);
          d_d       = magnitude(divisor, is_signed);
          r_d       = '0;
          cnt_d     = '0;
          neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = is_signed & dividend[WIDTH-1];
          zero_d    = (divisor == '0);
        end
      end

      ST_ITER: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          if (!sub_borrow) begin
            r_d = sub_diff;
            q_d = {q_q[WIDTH-2:0], 1'b1};
          end else begin
            r_d = shift_val;
            q_d = {q_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = ST_FIX;
          end
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          quotient_d  = neg_quo_q ? twos_neg(q_q) : q_q;
          remainder_d = neg_rem_q ? twos_neg(r_q) : r_q;
          div_zero_d  = zero_q;
          done_d      = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_seq_32b.sv
// Self-checking bench for div_seq_32b: directed vector table, randomized ops
// against a plain-arithmetic model, and handshake corner sequences.
module tb_div_seq_32b;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cancel;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_seq_32b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cancel    (cancel),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: MIPS div/divu semantics from plain division on magnitudes.
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic [31:0] ma, mb, mq, mr;
    ma = (sgn && a[31]) ? (32'd0 - a) : a;
    mb = (sgn && b[31]) ? (32'd0 - b) : b;
    if (mb == 0) begin
      mq = 32'hFFFF_FFFF;
      mr = ma;
    end else begin
      mq = ma / mb;
      mr = ma % mb;
    end
    q  = (sgn && (a[31] ^ b[31])) ? (32'd0 - mq) : mq;
    r  = (sgn && a[31]) ? (32'd0 - mr) : mr;
    dz = (b == 0);
  endtask

  // Issue one op and follow it to done (bounded). If poke_at > 0, a start with
  // other operands is driven for the cycle following negedge poke_at.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, output logic got, output int lat,
                        output int busy_cnt, output logic changed);
    logic [31:0] pq, pr;
    int n;
    @(negedge clk);
    is_signed = sgn; dividend = a; divisor = b; start = 1'b1;
    pq = quotient; pr = remainder;
    @(negedge clk);
    start = 1'b0;
    n = 1; got = 1'b0; busy_cnt = 0; changed = 1'b0;
    while (!got && n <= 60) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (quotient !== pq || remainder !== pr) changed = 1'b1;
        if (n == poke_at) begin
          start = 1'b1; is_signed = 1'b0; dividend = 32'd5; divisor = 32'd5;
        end
        @(negedge clk);
        start = 1'b0;
        n++;
      end
    end
    lat = n;
  endtask

  // Full directed op: result plus latency, busy width, stability and pulse width.
  task automatic do_vec(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int poke_at);
    logic got, changed;
    int lat, bcnt;
    run_op(sgn, a, b, poke_at, got, lat, bcnt, changed);
    check({name, " done seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(lat), 32'd34);
    check({name, " busy cycles"}, 32'(bcnt), 32'd33);
    check({name, " busy at done"}, 32'(busy), 32'd0);
    check({name, " outputs held"}, 32'(changed), 32'd0);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " div_zero"}, 32'(div_zero), 32'(edz));
    @(negedge clk);
    check({name, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic        got, changed, saw_done, dz;
    logic [31:0] a, b, eq, er;
    int          lat, bcnt;

    vecs[0] = '{"u 100/7",       1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
    vecs[1] = '{"s -7/2",        1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2] = '{"u FFFFFFF9/2",  1'b0, 32'hFFFFFFF9,  32'h00000002,  32'h7FFFFFFC,  32'h00000001,  1'b0};
    vecs[3] = '{"s min/-1",      1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h00000000,  1'b0};
    vecs[4] = '{"u max/max",     1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  32'h00000000,  1'b0};
    vecs[5] = '{"u 1234/0",      1'b0, 32'h00001234,  32'h00000000,  32'hFFFFFFFF,  32'h00001234,  1'b1};
    vecs[6] = '{"u 10/5",        1'b0, 32'd10,        32'd5,         32'd2,         32'd0,         1'b0};
    vecs[7] = '{"s 7/-2",        1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'h00000001,  1'b0};
    vecs[8] = '{"s -10/0",       1'b1, 32'hFFFFFFF6,  32'h00000000,  32'h00000001,  32'hFFFFFFF6,  1'b1};
    vecs[9] = '{"u 5/10",        1'b0, 32'd5,         32'd10,        32'd0,         32'd5,         1'b0};

    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_vec(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].eq, vecs[i].er, vecs[i].edz, 0);
    end

    // start during ITER cycle 10 is ignored.
    do_vec("start ignored 1000/3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 10);
    repeat (3) @(negedge clk);
    check("no queued op busy", 32'(busy), 32'd0);

    // cancel at ITER cycle 20: busy drops, no done, prior result kept.
    @(negedge clk);
    is_signed = 1'b1; dividend = 32'd77; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("cancel busy before", 32'(busy), 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel busy after", 32'(busy), 32'd0);
    // cancel in IDLE blocks a simultaneous start.
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("idle cancel blocks start", 32'(busy), 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("cancel no done", 32'(saw_done), 32'd0);
    check("cancel quotient kept", quotient, 32'd333);
    check("cancel remainder kept", remainder, 32'd1);

    // Asynchronous reset in ITER cycle 15.
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'hFFFF0000; divisor = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst quotient", quotient, 32'd0);
    check("async rst remainder", remainder, 32'd0);
    check("async rst div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_vec("after rst 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = 32'hFFFFFFFF - $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      is_signed = 1'($urandom_range(0, 1));
      ref_div(is_signed, a, b, eq, er, dz);
      run_op(is_signed, a, b, 0, got, lat, bcnt, changed);
      check($sformatf("rand%0d latency", i), 32'(lat), 32'd34);
      check($sformatf("rand%0d quotient", i), quotient, eq);
      check($sformatf("rand%0d remainder", i), remainder, er);
      check($sformatf("rand%0d div_zero", i), 32'(div_zero), 32'(dz));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
